vec_store_drain: RTL and testbench
==================================

// Module: vec_store_drain
// PURPOSE
//  Store buffer that sits directly downstream of the processor core's data-memory write port.
//  It captures one store request per cycle from the core: a scalar word or a 5-lane vector store.
//  It drains the buffered stores to data memory as 32-bit beats over a valid/ready handshake.
//  It stalls the core through st_ready when the buffer is full.
// PARAMETERS
//  DEPTH  4   buffered store entries; power of 2, >=2
//  LANES  5   words per vector store; matches the core's VecWriteData_0..4
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset (0 = reset)
//  st_valid   in   1          store request from core (MemWrite)
//  st_vec     in   1          1 = vector store (LANES beats), 0 = scalar store (1 beat)
//  st_addr    in   32         byte address from core (ALUResult)
//  st_data    in   32         scalar store word (WriteData)
//  st_vdata   in   LANES*32   vector lanes; lane i = st_vdata[32*i+31:32*i] (VecWriteData_i)
//  st_ready   out  1          buffer can accept a store this cycle
//  mem_valid  out  1          beat valid toward data memory
//  mem_ready  in   1          memory accepts the beat
//  mem_addr   out  32         beat byte address
//  mem_wdata  out  32         beat write data
//  count      out  $clog2(DEPTH)+1  number of occupied entries
//  busy       out  1          count!=0
// BEHAVIOUR
//  - Reset (async, reset==0): all pointers, count and lane counter go to 0, and the FSM enters IDLE.
//    Outputs during reset: st_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, count=0, busy=0.
//  - Enqueue: when st_valid && st_ready at a rising edge, store {st_vec, st_addr, st_data, st_vdata} at the write pointer.
//    The write pointer wraps modulo DEPTH.
//  - st_ready = (count < DEPTH). It is purely a function of registered count, with no same-cycle bypass.
//    At full, st_ready=0 even if a pop happens in that cycle.
//  - st_valid while st_ready=0 is ignored. The core is required to hold the request until st_ready=1.
//  - The drain FSM has two states, IDLE and SEND, plus lane counter ln (0..LANES-1).
//    IDLE: mem_valid=0. If count!=0 at a rising edge, go to SEND with ln=0.
//    SEND: mem_valid=1. The head entry drives the beat:
//      scalar: mem_addr = addr,       mem_wdata = st_data
//      vector: mem_addr = addr + 4*ln, mem_wdata = lane ln
//    Address addition is 32-bit and wraps modulo 2^32.
//    A beat completes on a rising edge with mem_valid && mem_ready.
//    On the last beat of an entry (scalar: always; vector: ln==LANES-1), pop the head and reset ln=0.
//      Stay in SEND if an entry remains after the pop (counting a simultaneous enqueue); otherwise go to IDLE.
//    On a non-last beat, ln increments.
//    Back-to-back beats are allowed: one beat per cycle while mem_ready=1.
//  - While mem_valid=1 and mem_ready=0, mem_addr and mem_wdata hold stable. mem_valid never drops without acceptance.
//  - Latency: a store enqueued at edge N has mem_valid=1 no earlier than cycle N+1 (after edge N+1 when previously IDLE).
//  - count: +1 on enqueue, -1 on pop, unchanged when both happen in the same cycle.
//  - Stores drain strictly in enqueue order. A vector's lanes issue in order 0..LANES-1.
//  - mem_addr/mem_wdata are don't-care while mem_valid=0. Drive 0 in IDLE.
//  - Reset mid-burst: remaining lanes and entries are discarded, and nothing is re-issued after reset.
// TESTING
//  1 Scalar store: st_valid=1, st_vec=0, addr=0x40, data=0xDEADBEEF, mem_ready=1
//    -> exactly one beat (0x40, 0xDEADBEEF); count returns to 0.
//  2 Vector store: addr=0x100, lanes=0x11,0x22,0x33,0x44,0x55, mem_ready=1
//    -> 5 consecutive beats at 0x100,0x104,0x108,0x10C,0x110 carrying 0x11..0x55.
//  3 Full: enqueue 4 vectors with mem_ready=0 -> count=4, st_ready=0, and a 5th request is ignored.
//    Then set mem_ready=1 -> 20 beats in order, with st_ready=1 after the first pop.
//  4 Backpressure: toggle mem_ready 1,0,0,1 during a vector
//    -> mem_addr/mem_wdata stay stable across stall cycles; no lane is skipped or repeated.
//  5 Wrap: vector store at addr=0xFFFFFFF8
//    -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
//  6 Reset mid-burst: pull reset low after lane 2 is accepted
//    -> mem_valid=0 and count=0 immediately; after release, no further beats.

Source files
------------

// File: rtl/vec_store_drain.sv
// Store buffer between the core's data-memory write port and data memory.
// Buffers scalar or LANES-wide vector stores and drains them as 32-bit beats.
module vec_store_drain #(
    parameter int DEPTH = 4,
    parameter int LANES = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic                     st_vec,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [LANES*32-1:0]      st_vdata,
    output logic                     st_ready,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic                 r_vec   [DEPTH];
    logic [31:0]          r_addr  [DEPTH];
    logic [31:0]          r_data  [DEPTH];
    logic [LANES*32-1:0]  r_vdata [DEPTH];

    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [LW-1:0] r_ln;
    state_t        r_state, w_state_nxt;

    logic          w_push, w_beat, w_last, w_pop;
    logic [31:0]   w_lane;

    assign st_ready  = (r_count < CW'(DEPTH));
    assign count     = r_count;
    assign busy      = (r_count != '0);
    assign mem_valid = (r_state == SEND);

    assign w_push = st_valid && st_ready;
    assign w_beat = (r_state == SEND) && mem_ready;
    assign w_last = !r_vec[r_rptr] || (r_ln == LW'(LANES - 1));
    assign w_pop  = w_beat && w_last;

    // Constant-index lane mux keeps every select in range for any ln encoding.
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_ln == LW'(i)) w_lane = r_vdata[r_rptr][32*i +: 32];
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == SEND) begin
            if (r_vec[r_rptr]) begin
                mem_addr  = r_addr[r_rptr] + (32'(r_ln) << 2);
                mem_wdata = w_lane;
            end else begin
                mem_addr  = r_addr[r_rptr];
                mem_wdata = r_data[r_rptr];
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_count != '0) w_state_nxt = SEND;
            SEND:    if (w_pop && (w_count_nxt == '0)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ln    <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (r_state != SEND)  r_ln <= '0;
            else if (w_beat)      r_ln <= w_last ? '0 : r_ln + 1'b1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_vec[r_wptr]   <= st_vec;
            r_addr[r_wptr]  <= st_addr;
            r_data[r_wptr]  <= st_data;
            r_vdata[r_wptr] <= st_vdata;
        end
    end

endmodule

// File: tb/tb_vec_store_drain.sv
// Directed bench for vec_store_drain: one task per scenario, beats captured by a monitor.
module tb_vec_store_drain;

    logic         clk = 1'b0;
    logic         reset;
    logic         st_valid, st_vec;
    logic [31:0]  st_addr, st_data;
    logic [159:0] st_vdata;
    logic         st_ready, mem_valid, mem_ready;
    logic [31:0]  mem_addr, mem_wdata;
    logic [2:0]   count;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    vec_store_drain #(.DEPTH(4), .LANES(5)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_vec(st_vec), .st_addr(st_addr), .st_data(st_data),
        .st_vdata(st_vdata), .st_ready(st_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change only just after posedge, so the negedge view predicts acceptance.
    always @(negedge clk) begin
        if (reset && mem_valid && mem_ready) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [159:0] mk_vdata(input logic [31:0] base);
        logic [159:0] v;
        for (int i = 0; i < 5; i++) v[32*i +: 32] = base + 32'(i);
        return v;
    endfunction

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic enq(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [159:0] vd);
        int n;
        st_valid = 1'b1; st_vec = v; st_addr = a; st_data = d; st_vdata = vd;
        n = 0;
        while (!st_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) begin
            checks++; failures++;
            $display("FAIL enq_timeout st_ready=%0b required=1", st_ready);
        end
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((count != 0 || mem_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n == 300) begin
            failures++;
            $display("FAIL drain_timeout count=%0d mem_valid=%0b required count=0 valid=0",
                     count, mem_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; st_valid = 1'b0; st_vec = 1'b0; st_addr = '0; st_data = '0;
        st_vdata = '0; mem_ready = 1'b0;
        #3;
        checks++;
        if ({st_ready, mem_valid, busy} !== 3'b100 || count !== 3'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs rdy=%0b vld=%0b busy=%0b cnt=%0d addr=%h data=%h required 1 0 0 0 0 0",
                     st_ready, mem_valid, busy, count, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_scalar();
        clear_q();
        mem_ready = 1'b1;
        enq(1'b0, 32'h40, 32'hDEADBEEF, '0);
        checks++;
        if (mem_valid !== 1'b0 || count !== 3'd1) begin
            failures++;
            $display("FAIL scalar_latency mem_valid=%0b count=%0d required 0 1", mem_valid, count);
        end
        wait_idle();
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h40 || q_data[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL scalar_beat n=%0d addr=%h data=%h required n=1 00000040 deadbeef",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'hx,
                     (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL scalar_count count=%0d busy=%0b required 0 0", count, busy);
        end
    endtask

    task automatic test_vector();
        clear_q();
        mem_ready = 1'b1;
        enq(1'b1, 32'h100, 32'h0, mk_vdata(32'h11) & {32'h0,32'h0,32'h0,32'h0,32'hFFFFFFFF}
            | {32'h55, 32'h44, 32'h33, 32'h22, 32'h0});
        wait_idle();
        checks++;
        if (q_addr.size() != 5) begin
            failures++;
            $display("FAIL vector_beats n=%0d required 5", q_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_addr[i] !== 32'h100 + 32'(4*i) || q_data[i] !== 32'h11 * 32'(i+1) ||
                    q_cyc[i] != q_cyc[0] + i) begin
                    failures++;
                    $display("FAIL vector_lane%0d addr=%h data=%h cyc=%0d required %h %h %0d",
                             i, q_addr[i], q_data[i], q_cyc[i], 32'h100 + 32'(4*i),
                             32'h11 * 32'(i+1), q_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_full();
        clear_q();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            enq(1'b1, 32'h200 + 32'(k*'h40), 32'h0, mk_vdata(32'(k*'h100)));
        checks++;
        if (count !== 3'd4 || st_ready !== 1'b0 || mem_valid !== 1'b1 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL full_state count=%0d rdy=%0b vld=%0b addr=%h required 4 0 1 00000200",
                     count, st_ready, mem_valid, mem_addr);
        end
        st_valid = 1'b1; st_vec = 1'b0; st_addr = 32'hBAD0; st_data = 32'hBAD;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (count !== 3'd4) begin
                failures++;
                $display("FAIL full_ignore count=%0d required 4", count);
            end
        end
        st_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (st_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL full_before_pop rdy=%0b count=%0d required 0 4", st_ready, count);
        end
        @(posedge clk); #1;
        checks++;
        if (st_ready !== 1'b1 || count !== 3'd3) begin
            failures++;
            $display("FAIL full_after_pop rdy=%0b count=%0d required 1 3", st_ready, count);
        end
        wait_idle();
        checks++;
        if (q_addr.size() != 20) begin
            failures++;
            $display("FAIL full_beats n=%0d required 20", q_addr.size());
        end else begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (q_addr[5*k+i] !== 32'h200 + 32'(k*'h40 + 4*i) ||
                        q_data[5*k+i] !== 32'(k*'h100 + i)) begin
                        failures++;
                        $display("FAIL full_order beat%0d addr=%h data=%h required %h %h", 5*k+i,
                                 q_addr[5*k+i], q_data[5*k+i], 32'h200 + 32'(k*'h40 + 4*i),
                                 32'(k*'h100 + i));
                    end
                end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] pat;
        int lane, n;
        pat = 8'b1110_1001;
        clear_q();
        mem_ready = 1'b0;
        enq(1'b1, 32'h300, 32'h0, mk_vdata(32'hA0));
        n = 0;
        while (!mem_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lane = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = pat[i];
            #1;
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h300 + 32'(4*lane) ||
                mem_wdata !== 32'hA0 + 32'(lane)) begin
                failures++;
                $display("FAIL bp_step%0d vld=%0b addr=%h data=%h required 1 %h %h", i,
                         mem_valid, mem_addr, mem_wdata, 32'h300 + 32'(4*lane), 32'hA0 + 32'(lane));
            end
            @(posedge clk); #1;
            if (pat[i]) lane++;
        end
        mem_ready = 1'b1;
        wait_idle();
        checks++;
        if (q_addr.size() != 5 || q_addr[4] !== 32'h310 || q_data[4] !== 32'hA4) begin
            failures++;
            $display("FAIL bp_beats n=%0d required 5 ending 00000310/000000a4", q_addr.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [5];
        exp_a = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8};
        clear_q();
        mem_ready = 1'b1;
        enq(1'b1, 32'hFFFFFFF8, 32'h0, mk_vdata(32'h700));
        wait_idle();
        checks++;
        if (q_addr.size() != 5) begin
            failures++;
            $display("FAIL wrap_beats n=%0d required 5", q_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_addr[i] !== exp_a[i] || q_data[i] !== 32'h700 + 32'(i)) begin
                    failures++;
                    $display("FAIL wrap_lane%0d addr=%h data=%h required %h %h", i, q_addr[i],
                             q_data[i], exp_a[i], 32'h700 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        mem_ready = 1'b1;
        enq(1'b0, 32'h800, 32'hC0DE0001, '0);
        enq(1'b0, 32'h804, 32'hC0DE0002, '0);
        enq(1'b0, 32'h808, 32'hC0DE0003, '0);
        wait_idle();
        checks++;
        if (q_addr.size() != 3) begin
            failures++;
            $display("FAIL b2b_beats n=%0d required 3", q_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_addr[i] !== 32'h800 + 32'(4*i) || q_data[i] !== 32'hC0DE0001 + 32'(i)) begin
                    failures++;
                    $display("FAIL b2b_beat%0d addr=%h data=%h required %h %h", i, q_addr[i],
                             q_data[i], 32'h800 + 32'(4*i), 32'hC0DE0001 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_midburst();
        clear_q();
        mem_ready = 1'b0;
        enq(1'b1, 32'h500, 32'h0, mk_vdata(32'h5000));
        enq(1'b0, 32'h600, 32'h6666, '0);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || count !== 3'd0 || st_ready !== 1'b1 || mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_immediate vld=%0b count=%0d rdy=%0b addr=%h required 0 0 1 0",
                     mem_valid, count, st_ready, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (q_addr.size() != 3 || q_addr[2] !== 32'h508 || q_data[2] !== 32'h5002 ||
            count !== 3'd0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_after n=%0d count=%0d vld=%0b required n=3 last 00000508 count 0 vld 0",
                     q_addr.size(), count, mem_valid);
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_vector();
        test_full();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
